// File: rtl/cic_stream_arbiter.sv
// rtl/cic_stream_arbiter.sv - round-robin merge of NCH decimator streams into one registered port
//
// Purpose: picks one of NCH enabled, valid upstream sample streams per cycle
// in round-robin order and registers it onto a single downstream port.
// The output register also acts as a one-deep skid stage.
//
// Ports:
//   in_clock    system clock, rising edge
//   in_reset_n  asynchronous active-low reset
//   cfg_enable  [NCH]       per-channel arbitration enable
//   in_valid    [NCH]       per-channel sample valid
//   in_ready    [NCH]       per-channel accept, at most one bit set
//   in_data     [NCH*DW]    flattened samples, channel i at [i*DW +: DW]
//   out_valid   registered sample valid
//   out_ready   downstream accept
//   out_data    [DW]        registered sample
//   out_chan    [ChWidth]   channel that sourced out_data
module cic_stream_arbiter #(
  parameter int  NCH        = 4,
  parameter int  DATA_WIDTH = 24,
  localparam int ChWidth    = (NCH == 1) ? 1 : $clog2(NCH)
) (
  input  logic                      in_clock,
  input  logic                      in_reset_n,
  input  logic [NCH-1:0]            cfg_enable,
  input  logic [NCH-1:0]            in_valid,
  output logic [NCH-1:0]            in_ready,
  input  logic [NCH*DATA_WIDTH-1:0] in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH-1:0]     out_data,
  output logic [ChWidth-1:0]        out_chan
);

  if (NCH < 1 || DATA_WIDTH < 1) begin : g_param_check
    $error("cic_stream_arbiter: NCH and DATA_WIDTH must both be at least 1");
  end

  logic                  load;
  logic [NCH-1:0]        req;
  logic                  gnt_found;
  logic [ChWidth-1:0]    gnt_idx;
  logic [DATA_WIDTH-1:0] gnt_data;
  logic [ChWidth-1:0]    rr_ptr;
  logic [ChWidth-1:0]    rr_next;

  // Output register can take a new sample when empty or being drained.
  assign load = !out_valid || out_ready;
  assign req  = in_valid & cfg_enable;

  // Search upward from rr_ptr; the explicit subtract keeps the wrap correct
  // when NCH is not a power of two.
  always_comb begin
    int idx;
    idx       = 0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 0; k < NCH; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NCH) idx = idx - NCH;
      if (!gnt_found && req[ChWidth'(idx)]) begin
        gnt_found = 1'b1;
        gnt_idx   = ChWidth'(idx);
      end
    end
  end

  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < NCH; i++) begin
      if (gnt_idx == ChWidth'(i)) gnt_data = in_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign rr_next = (gnt_idx == ChWidth'(NCH - 1)) ? '0 : gnt_idx + ChWidth'(1);

  // Gated by reset so no upstream handshake completes while the register
  // is being cleared.
  assign in_ready = (in_reset_n && load && gnt_found) ? (NCH'(1) << gnt_idx) : '0;

  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      rr_ptr    <= '0;
    end else if (load) begin
      if (gnt_found) begin
        out_valid <= 1'b1;
        out_data  <= gnt_data;
        out_chan  <= gnt_idx;
        rr_ptr    <= rr_next;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cic_stream_arbiter.sv
// tb/tb_cic_stream_arbiter.sv - scoreboard bench for cic_stream_arbiter (NCH=4, DATA_WIDTH=24)
module tb_cic_stream_arbiter;

  localparam int NCH = 4;
  localparam int DW  = 24;

  logic              in_clock = 1'b0;
  logic              in_reset_n;
  logic [NCH-1:0]    cfg_enable;
  logic [NCH-1:0]    in_valid;
  logic [NCH-1:0]    in_ready;
  logic [NCH*DW-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DW-1:0]     out_data;
  logic [1:0]        out_chan;

  cic_stream_arbiter #(.NCH(NCH), .DATA_WIDTH(DW)) dut (
    .in_clock   (in_clock),
    .in_reset_n (in_reset_n),
    .cfg_enable (cfg_enable),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_chan   (out_chan)
  );

  always #5 in_clock = ~in_clock;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] sb_q[$];
  logic        m_ovalid;
  int          m_ptr;
  int          wait_cnt[NCH];

  localparam logic [NCH*DW-1:0] DAT_C = {24'h000013, 24'h000012, 24'h000011, 24'h000010};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // One cycle: drive after the rising edge, evaluate at the falling edge,
  // advance the reference model for the transfer at the next rising edge.
  task automatic step(input logic [3:0] en, input logic [3:0] vld, input logic rdy,
                      input logic [NCH*DW-1:0] dat, output int acc);
    logic [3:0]  req;
    logic [3:0]  exp_rdy;
    logic        load;
    logic [31:0] head;
    int          g;
    @(posedge in_clock);
    #1;
    cfg_enable = en;
    in_valid   = vld;
    out_ready  = rdy;
    in_data    = dat;
    @(negedge in_clock);
    req  = vld & en;
    load = !m_ovalid || rdy;
    g    = -1;
    for (int k = 0; k < NCH; k++) begin
      int idx;
      idx = (m_ptr + k) % NCH;
      if (g < 0 && req[idx]) g = idx;
    end
    exp_rdy = (load && g >= 0) ? 4'(1 << g) : 4'b0;
    check("in_ready", {28'b0, in_ready}, {28'b0, exp_rdy});
    check("out_valid", {31'b0, out_valid}, {31'b0, m_ovalid});
    if (m_ovalid && rdy) begin
      check("sb_nonempty", {31'b0, sb_q.size() > 0}, 32'd1);
      if (sb_q.size() > 0) begin
        head = sb_q.pop_front();
        check("out_chan_data", {6'b0, out_chan, out_data}, head);
      end
    end
    for (int i = 0; i < NCH; i++) if (!req[i]) wait_cnt[i] = 0;
    acc = -1;
    if (load) begin
      if (g >= 0) begin
        sb_q.push_back({6'b0, 2'(g), dat[g*DW +: DW]});
        for (int i = 0; i < NCH; i++) begin
          if (req[i] && i != g) wait_cnt[i]++;
          else wait_cnt[i] = 0;
          if (req[i]) check("fairness", {31'b0, wait_cnt[i] <= NCH - 1}, 32'd1);
        end
        m_ptr    = (g + 1) % NCH;
        m_ovalid = 1'b1;
        acc      = g;
      end else begin
        m_ovalid = 1'b0;
      end
    end
  endtask

  // Asserts reset at the current time (possibly mid-cycle) and checks the
  // outputs clear without waiting for a clock edge.
  task automatic do_reset();
    in_reset_n = 1'b0;
    cfg_enable = 4'hf;
    in_valid   = 4'hf;
    out_ready  = 1'b1;
    in_data    = DAT_C;
    #2;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_data", {8'b0, out_data}, 32'd0);
    check("rst_out_chan", {30'b0, out_chan}, 32'd0);
    check("rst_in_ready", {28'b0, in_ready}, 32'd0);
    @(posedge in_clock);
    @(negedge in_clock);
    in_valid   = 4'h0;
    in_reset_n = 1'b1;
    m_ovalid   = 1'b0;
    m_ptr      = 0;
    sb_q.delete();
    for (int i = 0; i < NCH; i++) wait_cnt[i] = 0;
  endtask

  initial begin
    int          acc;
    int          ord034[6];
    logic [3:0]  pend;
    logic [19:0] seq[NCH];
    logic [3:0]  en_r;
    logic        rdy_r;
    logic [NCH*DW-1:0] dr;

    ord034 = '{0, 1, 3, 0, 1, 3};

    // All channels valid, full throughput, strict rotation.
    do_reset();
    for (int k = 0; k < 9; k++) begin
      step(4'hf, 4'hf, 1'b1, DAT_C, acc);
      if (k >= 1) begin
        check("rot_valid", {31'b0, out_valid}, 32'd1);
        check("rot_chan", {30'b0, out_chan}, 32'((k - 1) % 4));
        check("rot_data", {8'b0, out_data}, 32'h10 + 32'((k - 1) % 4));
      end
    end

    // Backpressure holds the registered sample; next grant goes to channel 3.
    do_reset();
    step(4'hf, 4'b1010, 1'b0, DAT_C, acc);
    for (int k = 0; k < 5; k++) begin
      step(4'hf, 4'b1010, 1'b0, DAT_C, acc);
      check("bp_valid", {31'b0, out_valid}, 32'd1);
      check("bp_chan", {30'b0, out_chan}, 32'd1);
      check("bp_data", {8'b0, out_data}, 32'h11);
      check("bp_in_ready", {28'b0, in_ready}, 32'd0);
    end
    step(4'hf, 4'b1010, 1'b1, DAT_C, acc);
    step(4'hf, 4'b0000, 1'b1, DAT_C, acc);
    check("bp_next_chan", {30'b0, out_chan}, 32'd3);
    check("bp_next_data", {8'b0, out_data}, 32'h13);

    // Channel 2 disabled.
    do_reset();
    for (int k = 0; k < 7; k++) begin
      step(4'b1011, 4'hf, 1'b1, DAT_C, acc);
      check("dis_ready2", {31'b0, in_ready[2]}, 32'd0);
      if (k >= 1) check("dis_chan", {30'b0, out_chan}, 32'(ord034[k - 1]));
    end

    // Single sample from channel 2, then idle; pointer lands on 3.
    do_reset();
    step(4'hf, 4'b0100, 1'b1, DAT_C, acc);
    step(4'hf, 4'b0000, 1'b1, DAT_C, acc);
    check("one_valid", {31'b0, out_valid}, 32'd1);
    check("one_chan", {30'b0, out_chan}, 32'd2);
    check("one_data", {8'b0, out_data}, 32'h12);
    step(4'hf, 4'b0000, 1'b1, DAT_C, acc);
    check("one_idle", {31'b0, out_valid}, 32'd0);
    step(4'hf, 4'hf, 1'b1, DAT_C, acc);
    step(4'hf, 4'b0000, 1'b1, DAT_C, acc);
    check("one_ptr3", {30'b0, out_chan}, 32'd3);

    // Reset while a channel 2 sample is pending; first grant after is 0.
    do_reset();
    step(4'hf, 4'b0100, 1'b0, DAT_C, acc);
    step(4'hf, 4'b0000, 1'b0, DAT_C, acc);
    check("mid_chan", {30'b0, out_chan}, 32'd2);
    do_reset();
    step(4'hf, 4'hf, 1'b1, DAT_C, acc);
    step(4'hf, 4'b0000, 1'b1, DAT_C, acc);
    check("mid_first", {30'b0, out_chan}, 32'd0);

    // Random valid/ready/enable; sources hold valid until accepted.
    do_reset();
    pend = '0;
    en_r = 4'hf;
    for (int i = 0; i < NCH; i++) seq[i] = '0;
    dr = '0;
    for (int c = 0; c < 10000; c++) begin
      if (c % 50 == 0) en_r = (c % 200 == 0) ? 4'hf : 4'($urandom_range(0, 15));
      for (int i = 0; i < NCH; i++) begin
        if (!pend[i] && $urandom_range(0, 2) != 0) pend[i] = 1'b1;
        dr[i*DW +: DW] = {4'(i), seq[i]};
      end
      rdy_r = ($urandom_range(0, 3) != 0);
      step(en_r, pend, rdy_r, dr, acc);
      if (acc >= 0) begin
        pend[acc] = 1'b0;
        seq[acc]  = seq[acc] + 20'd1;
      end
    end
    repeat (4) step(4'hf, 4'h0, 1'b1, dr, acc);
    check("sb_drained", sb_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
